rdyacpt_pack: RTL
=================

# rdyacpt_pack

Width-converting packer that sits directly downstream of the ready/accept pipeline stage. It consumes a stream of `WIDTH`-bit beats under ready/accept handshake and assembles every `RATIO` consecutive beats into one `WIDTH*RATIO`-bit word. The word is presented on a ready/accept output port. Beat assembly and output holding are separate registers, so full throughput is sustained under continuous flow.

## Interface
- `WIDTH`, default 8: input beat width in bits.
- `RATIO`, default 4: beats per output word; legal values are ≥ 2.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `upstream_rdy`  input  1  upstream beat valid.
- `upstream_data`  input  `WIDTH`  upstream beat.
- `upstream_acpt`  output  1  packer accepts beat this cycle.
- `downstream_rdy`  output  1  packed word valid.
- `downstream_data`  output  `WIDTH*RATIO`  packed word.
- `downstream_acpt`  input  1  consumer accepts word this cycle.
- `downstream_par`  output  1  even parity of `downstream_data`. Present only with `RDYACPT_PACK_PARITY_EN`.

## Operation
- A transfer occurs on a rising edge where rdy and acpt are both high on that port. No other condition constitutes a transfer.
- State:
  - `cnt` is the beat index, 0..`RATIO-1`, `$clog2(RATIO)` bits.
  - The assembly register holds `(RATIO-1)*WIDTH` bits.
  - The output register holds `WIDTH*RATIO` data bits plus a valid bit, which drives `downstream_rdy`.
- `upstream_acpt` is combinational: `(cnt != RATIO-1) | ~downstream_rdy | downstream_acpt`.
- Accepted beat with `cnt < RATIO-1`:
  - The beat is written into assembly slot `cnt`, i.e. bits `[cnt*WIDTH +: WIDTH]`.
  - `cnt` increments.
- Accepted beat with `cnt == RATIO-1`:
  - `downstream_data` ← {beat, assembly register}, so the first beat lands in the LSBs (little-endian).
  - `downstream_rdy` ← 1.
  - `cnt` wraps to 0.
- Output transfer without a simultaneous last-beat load: `downstream_rdy` ← 0. `downstream_data` holds its last value.
- Same edge has an output transfer and a last-beat load: the new word is loaded and `downstream_rdy` stays 1, giving back-to-back words with no bubble.
- While `downstream_rdy` = 1 and `downstream_acpt` = 0, `downstream_data` is stable.
- Beats 0..`RATIO-2` of the next word continue to be accepted while a word is held. Only the last beat stalls.
- No beat is dropped or duplicated. Output words appear in arrival order.

## Timing
- Reset values, applied asynchronously on `reset_n` low:
  - `cnt` = 0, assembly register = 0.
  - `downstream_rdy` = 0, `downstream_data` = 0, `downstream_par` = 0.
  - `upstream_acpt` = 1, since it follows combinationally from `cnt` = 0.
- Latency: a last beat accepted at edge N gives `downstream_rdy` = 1 immediately after edge N.
- Throughput: one beat per cycle sustained when `downstream_acpt` is held high.
- `upstream_acpt` depends combinationally on `downstream_acpt` and on registered state only. It never depends on `upstream_rdy`.
- `upstream_data` is ignored whenever no transfer occurs. `downstream_acpt` is ignored while `downstream_rdy` = 0.
- Reset asserted mid-word or with a word held:
  - The partial word and the held word are discarded.
  - After reset release, the first accepted beat is treated as beat 0.
- Reset release is not required to be synchronous to any particular phase of `clk`. No transfer is counted on the edge where `reset_n` is still low.

## Configuration
- `RDYACPT_PACK_PARITY_EN` defined:
  - Port `downstream_par` exists. It is registered alongside `downstream_data` as the XOR of all bits of the loaded word.
  - It updates only when a new word loads and resets to 0.
- Macro undefined:
  - Port and parity logic are absent.
  - All other behaviour is identical, cycle for cycle.

## Test plan
All scenarios use `WIDTH`=8, `RATIO`=4.
- **Basic pack.** `downstream_acpt`=1. Beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - `downstream_data` = 0x44332211 with `downstream_rdy` = 1 for exactly one cycle, after the 4th edge.
- **Backpressure.** `downstream_acpt`=0. Stream 8 beats 0x01..0x08.
  - First word 0x04030201 is held stable.
  - Beats 0x05..0x07 are accepted. `upstream_acpt` = 0 while 0x08 is offered.
  - On `downstream_acpt`=1: 0x08 is accepted on the same edge and the next word is 0x08070605.
- **Back-to-back.** `downstream_acpt`=1 and `upstream_rdy`=1 continuous for 12 beats.
  - 3 words; `downstream_rdy` pulses every 4th cycle; `upstream_acpt` is never 0.
- **Simultaneous.** Word held while the last beat of the next word is offered and `downstream_acpt` rises on the same cycle.
  - Both transfer on one edge and `downstream_rdy` stays 1.
- **Reset mid-word.** After beats 0xAA, 0xBB, pulse `reset_n` low. Then send 0x01, 0x02, 0x03, 0x04.
  - Output is 0x04030201 and no 0xAA/0xBB bytes appear.
  - All outputs are at reset values during reset.
- **Parity** (`RDYACPT_PACK_PARITY_EN` defined).
  - Word 0x00000001 → `downstream_par` = 1.
  - Word 0x44332211 → `downstream_par` = 0.

Source files
------------

// File: rtl/rdyacpt_pack.sv
// rdyacpt_pack: ready/accept width-converting packer.
// Collects RATIO consecutive WIDTH-bit beats into one WIDTH*RATIO-bit word.
// The first beat lands in the least significant bits.
// The partially assembled word and the held output word are kept in separate
// registers. Beats 0..RATIO-2 of the next word can therefore be accepted while
// a finished word waits downstream, and only the last beat ever stalls.
// Optional feature: define RDYACPT_PACK_PARITY_EN to add the downstream_par
// output. It is the registered even parity (XOR of all bits) of the held word.
// RATIO must be at least 2.

module rdyacpt_pack #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    // upstream beat port
    input  logic                     upstream_rdy,
    input  logic [WIDTH-1:0]         upstream_data,
    output logic                     upstream_acpt,
    // downstream word port
    output logic                     downstream_rdy,
    output logic [WIDTH*RATIO-1:0]   downstream_data,
`ifdef RDYACPT_PACK_PARITY_EN
    output logic                     downstream_par,
`endif
    input  logic                     downstream_acpt
);

    localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int ASM_W  = (RATIO - 1) * WIDTH;
    localparam int WORD_W = WIDTH * RATIO;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q, cnt_d;          // index of the next beat
    logic              out_vld_q, out_vld_d;  // a word is held downstream
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [ASM_W-1:0]  asm_w;                 // all assembly slots, flattened

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic cnt_is_last;
    logic in_xfer;
    logic out_xfer;
    logic last_load;

    assign cnt_is_last = (cnt_q == LAST_IDX);

    // Only the last beat depends on room downstream. Room exists when no
    // word is held, or when the held word leaves on this same edge.
    // upstream_rdy is deliberately left out so there is no rdy->acpt path.
    assign upstream_acpt = ~cnt_is_last | ~out_vld_q | downstream_acpt;

    assign in_xfer   = upstream_rdy & upstream_acpt;
    assign out_xfer  = out_vld_q & downstream_acpt;
    assign last_load = in_xfer & cnt_is_last;

    // ------------------------------------------------------------------
    // Assembly slots: one register per non-final beat position. Each slot
    // has its own write enable, so the slot registers are held unchanged
    // except when the beat for that position arrives.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < RATIO - 1; gi++) begin : g_slot
            logic [WIDTH-1:0] slot_q, slot_d;
            logic             slot_we;

            assign slot_we = in_xfer & (cnt_q == CNT_W'(gi));

            // Next value of this slot: capture the beat when it is addressed.
            always_comb begin
                slot_d = slot_q;
                if (slot_we) begin
                    slot_d = upstream_data;
                end
            end

            // Slot register; a reset clears any partial word.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign asm_w[gi*WIDTH +: WIDTH] = slot_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic for the beat counter and output holding register.
    // ------------------------------------------------------------------

    // Beat counter: advance on every accepted beat and wrap after the last one.
    always_comb begin
        cnt_d = cnt_q;
        if (in_xfer) begin
            if (cnt_is_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output register: a load takes priority over an output transfer. This
    // keeps downstream_rdy high across back-to-back words. After a transfer
    // with no new load, the data is left unchanged and only the valid bit drops.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (last_load) begin
            out_vld_d  = 1'b1;
            out_data_d = {upstream_data, asm_w};
        end else if (out_xfer) begin
            out_vld_d  = 1'b0;
        end
    end

    // Counter and output registers; a reset discards both the partial word
    // and the held word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign downstream_rdy  = out_vld_q;
    assign downstream_data = out_data_q;

`ifdef RDYACPT_PACK_PARITY_EN
    // ------------------------------------------------------------------
    // Parity of the held word. It is computed from the word being loaded,
    // so it always matches downstream_data with no extra cycle of delay.
    // ------------------------------------------------------------------
    logic par_q, par_d;

    // Parity next value: recompute only when a new word loads.
    always_comb begin
        par_d = par_q;
        if (last_load) begin
            par_d = ^out_data_d;
        end
    end

    // Parity register, cleared together with the data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign downstream_par = par_q;
`endif

endmodule
